// File: rtl/interface_hcsr04_uc.sv
// Control unit for the HC-SR04 datapath: clears the datapath, fires a trigger, waits
// for echo or timeout, retries a bounded number of times, and reports done/failure.
module interface_hcsr04_uc #(
    parameter int MAX_TENT = 3,
    parameter int NT       = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          medir,
    input  logic          fim_medida,
    input  logic          fim_timeout,
    output logic          zera,
    output logic          gera,
    output logic          registra,
    output logic          conta_timeout,
    output logic          zera_timeout,
    output logic          pronto,
    output logic          falha,
    output logic [NT-1:0] db_tentativas,
    output logic [3:0]    db_estado
);

    typedef enum logic [3:0] {
        INICIAL  = 4'h0,
        PREPARA  = 4'h1,
        ENVIA    = 4'h2,
        ESPERA   = 4'h3,
        ARMAZENA = 4'h4,
        FINAL    = 4'h5,
        TIMEOUT  = 4'h6,
        ERRO     = 4'hE
    } state_t;

    localparam logic [NT-1:0] MAX_T = NT'(MAX_TENT);

    // ctrl bit order: zera, gera, registra, conta_timeout, zera_timeout, pronto, falha
    localparam logic [6:0] C_PREPARA  = 7'b1000100;
    localparam logic [6:0] C_ENVIA    = 7'b0100000;
    localparam logic [6:0] C_ESPERA   = 7'b0001000;
    localparam logic [6:0] C_ARMAZENA = 7'b0010000;
    localparam logic [6:0] C_FINAL    = 7'b0000010;
    localparam logic [6:0] C_TIMEOUT  = 7'b0000100;
    localparam logic [6:0] C_ERRO     = 7'b0000011;

    state_t        state_reg, state_next;
    logic [NT-1:0] tent_reg;
    logic [6:0]    ctrl_reg, ctrl_next;

    always_comb begin
        state_next = INICIAL;
        case (state_reg)
            INICIAL:  state_next = medir ? PREPARA : INICIAL;
            PREPARA:  state_next = ENVIA;
            ENVIA:    state_next = ESPERA;
            // A measurement completing in the same cycle as the timeout is still a success
            ESPERA: begin
                if (fim_medida)
                    state_next = ARMAZENA;
                else if (fim_timeout)
                    state_next = TIMEOUT;
                else
                    state_next = ESPERA;
            end
            ARMAZENA: state_next = FINAL;
            FINAL:    state_next = INICIAL;
            TIMEOUT:  state_next = (tent_reg < MAX_T) ? PREPARA : ERRO;
            ERRO:     state_next = INICIAL;
            default:  state_next = INICIAL;
        endcase
    end

    // Outputs are decoded from the upcoming state and registered, so they line up with state_reg
    always_comb begin
        ctrl_next = '0;
        case (state_next)
            PREPARA:  ctrl_next = C_PREPARA;
            ENVIA:    ctrl_next = C_ENVIA;
            ESPERA:   ctrl_next = C_ESPERA;
            ARMAZENA: ctrl_next = C_ARMAZENA;
            FINAL:    ctrl_next = C_FINAL;
            TIMEOUT:  ctrl_next = C_TIMEOUT;
            ERRO:     ctrl_next = C_ERRO;
            default:  ctrl_next = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= INICIAL;
            tent_reg  <= '0;
            ctrl_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ctrl_reg  <= ctrl_next;
            if (state_reg == INICIAL && medir)
                tent_reg <= '0;
            else if (state_reg == ENVIA && tent_reg < MAX_T)
                tent_reg <= tent_reg + NT'(1);
        end
    end

    assign {zera, gera, registra, conta_timeout, zera_timeout, pronto, falha} = ctrl_reg;
    assign db_tentativas = tent_reg;
    assign db_estado     = state_reg;

endmodule

// File: tb/tb_interface_hcsr04_uc.sv
// Cycle-accurate check of interface_hcsr04_uc against a request-level timeline model
// built from the protocol rules, with randomized echo/timeout timing and outcomes.
module tb_interface_hcsr04_uc;

    localparam int MAX_TENT = 3;
    localparam int NT       = 3;

    localparam logic [6:0] E_IDLE = 7'b0000000;
    localparam logic [6:0] E_ZERA = 7'b1000000;
    localparam logic [6:0] E_GERA = 7'b0100000;
    localparam logic [6:0] E_REG  = 7'b0010000;
    localparam logic [6:0] E_CNT  = 7'b0001000;
    localparam logic [6:0] E_ZT   = 7'b0000100;
    localparam logic [6:0] E_PR   = 7'b0000010;
    localparam logic [6:0] E_FA   = 7'b0000001;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          medir = 1'b0;
    logic          fim_medida = 1'b0;
    logic          fim_timeout = 1'b0;
    logic          zera, gera, registra, conta_timeout, zera_timeout, pronto, falha;
    logic [NT-1:0] db_tentativas;
    logic [3:0]    db_estado;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [6:0]    ctrl;
        logic [3:0]    st;
        logic [NT-1:0] tent;
        logic          md;
        logic          fm;
        logic          ft;
    } step_t;

    step_t         q[$];
    logic [NT-1:0] model_t = '0;

    interface_hcsr04_uc #(.MAX_TENT(MAX_TENT), .NT(NT)) dut (
        .clock(clock), .reset(reset), .medir(medir),
        .fim_medida(fim_medida), .fim_timeout(fim_timeout),
        .zera(zera), .gera(gera), .registra(registra),
        .conta_timeout(conta_timeout), .zera_timeout(zera_timeout),
        .pronto(pronto), .falha(falha),
        .db_tentativas(db_tentativas), .db_estado(db_estado)
    );

    always #10 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_outputs(input logic [6:0] ctrl, input logic [3:0] st, input logic [NT-1:0] tent);
        chk("ctrl", 16'({zera, gera, registra, conta_timeout, zera_timeout, pronto, falha}), 16'(ctrl));
        chk("estado", 16'(db_estado), 16'(st));
        chk("tentativas", 16'(db_tentativas), 16'(tent));
    endtask

    task automatic push(input logic [6:0] ctrl, input logic [3:0] st, input logic md,
                        input logic fm, input logic ft);
        step_t s;
        s.ctrl = ctrl; s.st = st; s.tent = model_t; s.md = md; s.fm = fm; s.ft = ft;
        q.push_back(s);
    endtask

    function automatic logic rnd_medir();
        return 1'($urandom_range(0, 1));
    endfunction

    // mode per attempt: 0 echo, 1 timeout, 2 both in same cycle, -1 random
    task automatic plan_request(input int gap, input int dly, input int m0, input int m1, input int m2);
        int mode;
        int d;
        for (int i = 0; i < gap; i++) push(E_IDLE, 4'h0, 1'b0, 1'b0, 1'b0);
        push(E_IDLE, 4'h0, 1'b1, 1'b0, 1'b0);
        model_t = '0;
        for (int a = 0; a < MAX_TENT; a++) begin
            push(E_ZERA | E_ZT, 4'h1, rnd_medir(), 1'b0, 1'b0);
            push(E_GERA, 4'h2, rnd_medir(), 1'b0, 1'b0);
            if (model_t < NT'(MAX_TENT)) model_t = model_t + NT'(1);
            mode = (a == 0) ? m0 : (a == 1) ? m1 : m2;
            if (mode < 0)
                mode = ($urandom_range(0, 9) < 6) ? 1 : int'($urandom_range(0, 1)) * 2;
            d = (dly < 0) ? int'($urandom_range(0, 15)) : dly;
            for (int i = 0; i < d; i++) push(E_CNT, 4'h3, rnd_medir(), 1'b0, 1'b0);
            push(E_CNT, 4'h3, rnd_medir(), mode != 1, mode != 0);
            if (mode != 1) begin
                push(E_REG, 4'h4, rnd_medir(), 1'b0, 1'b0);
                push(E_PR, 4'h5, rnd_medir(), 1'b0, 1'b0);
                return;
            end
            push(E_ZT, 4'h6, rnd_medir(), 1'b0, 1'b0);
            if (int'(model_t) >= MAX_TENT) begin
                push(E_PR | E_FA, 4'hE, rnd_medir(), 1'b0, 1'b0);
                return;
            end
        end
    endtask

    task automatic play();
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            @(posedge clock);
            #1;
            check_outputs(s.ctrl, s.st, s.tent);
            medir       = s.md;
            fim_medida  = s.fm;
            fim_timeout = s.ft;
        end
    endtask

    initial begin
        // Reset held for two edges: everything cleared
        repeat (2) @(posedge clock);
        #1;
        check_outputs(E_IDLE, 4'h0, '0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) push(E_IDLE, 4'h0, 1'b0, 1'b0, 1'b0);
        play();

        plan_request(2, 19, 0, 0, 0);     // single echo 20 cycles after gera
        plan_request(1, -1, 1, 1, 1);     // all attempts time out
        plan_request(0, -1, 1, 0, 0);     // timeout then echo
        plan_request(3, 5, 2, 0, 0);      // echo and timeout together
        plan_request(1, 0, 1, 2, 1);      // immediate events, success on second try
        play();

        for (int r = 0; r < 25; r++) begin
            plan_request(int'($urandom_range(0, 3)), -1, -1, -1, -1);
            play();
        end

        // Abort a request in ESPERA with reset
        plan_request(1, 0, 0, 0, 0);
        while (q.size() > 0 && q[q.size() - 1].st != 4'h3) void'(q.pop_back());
        q[q.size() - 1].fm = 1'b0;
        q[q.size() - 1].ft = 1'b0;
        push(E_CNT, 4'h3, 1'b0, 1'b0, 1'b0);
        play();
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_outputs(E_IDLE, 4'h0, '0);
        reset = 1'b1;
        medir = 1'b0;
        model_t = '0;

        plan_request(2, 7, 0, 0, 0);
        for (int i = 0; i < 4; i++) push(E_IDLE, 4'h0, 1'b0, 1'b0, 1'b0);
        play();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
